// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor: FSM state encoding,
// default cycle budgets and counter widths.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 4;
    localparam int DEF_CNT_W               = 24;

    localparam int LOSS_CNT_W = 8;
    localparam int RETRY_W    = 4;

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the lock supervisor (master) and the PLL / system side (slave).
interface pll_lock_supervisor_if;
    import pll_sup_pkg::*;

    // Level signals, no valid/ready handshake: pll_locked is asynchronous and is
    // synchronized inside the supervisor; clear_fault is a one-refclk pulse that
    // is acted on only while the supervisor sits in S_FAULT.
    logic                  pll_rst;
    logic                  pll_locked;
    logic                  clear_fault;
    logic                  sys_rst;
    logic                  ready;
    logic                  fault;
    logic [LOSS_CNT_W-1:0] lock_loss_count;
    logic [RETRY_W-1:0]    retry_count;
    state_t                state;

    modport master (
        output pll_rst, sys_rst, ready, fault, lock_loss_count, retry_count, state,
        input  pll_locked, clear_fault
    );

    modport slave (
        input  pll_rst, sys_rst, ready, fault, lock_loss_count, retry_count, state,
        output pll_locked, clear_fault
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset pulses, qualifies lock stability, retries a PLL that never
// locks and releases a registered system reset once lock has been stable.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_supervisor_if.master sup
);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [RETRY_W-1:0]    retry, retry_n;
    logic [LOSS_CNT_W-1:0] loss, loss_n;
    logic                  pll_rst_q, sys_rst_q, ready_q, fault_q;
    logic                  lock_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (sup.pll_locked),
        .q   (lock_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET;
            cnt       <= '0;
            retry     <= '0;
            loss      <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry     <= retry_n;
            loss      <= loss_n;
            // Outputs are decoded from the next state so they change on the transition edge.
            pll_rst_q <= (state_n == S_RESET) || (state_n == S_FAULT);
            sys_rst_q <= (state_n != S_RUN);
            ready_q   <= (state_n == S_RUN);
            fault_q   <= (state_n == S_FAULT);
        end
    end

    always_comb begin
        state_n = state;
        retry_n = retry;
        loss_n  = loss;
        unique case (state)
            S_RESET: begin
                if (cnt == RST_LAST) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a timeout landing in the same cycle.
                if (lock_s) begin
                    state_n = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_n = retry + 1'b1;
                    state_n = (retry_n == RETRY_LIMIT) ? S_FAULT : S_RESET;
                end
            end
            S_STABLE: begin
                if (!lock_s)                 state_n = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_n = S_RUN;
            end
            S_RUN: begin
                if (!lock_s) begin
                    if (loss != '1) loss_n = loss + 1'b1;
                    state_n = S_RESET;
                end
            end
            S_FAULT: begin
                if (sup.clear_fault) begin
                    retry_n = '0;
                    state_n = S_RESET;
                end
            end
            default: state_n = S_RESET;
        endcase
        if ((state_n == S_RUN) && (state != S_RUN)) retry_n = '0;
        cnt_n = (state_n != state) ? '0 : cnt + 1'b1;
    end

    assign sup.pll_rst         = pll_rst_q;
    assign sup.sys_rst         = sys_rst_q;
    assign sup.ready           = ready_q;
    assign sup.fault           = fault_q;
    assign sup.lock_loss_count = loss;
    assign sup.retry_count     = retry;
    assign sup.state           = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short cycle budgets
// (pulse 4, stable 8, timeout 32, two retries).
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    logic refclk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    pll_lock_supervisor_if sup();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2),
        .CNT_W               (24)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .sup    (sup)
    );

    // ---------------- clock / reset ----------------
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"}, sup.pll_rst, 1);
        check({tag, "_sys_rst"}, sup.sys_rst, 1);
        check({tag, "_ready"},   sup.ready,   0);
        check({tag, "_fault"},   sup.fault,   0);
        check({tag, "_loss"},    sup.lock_loss_count, 0);
        check({tag, "_retry"},   sup.retry_count, 0);
        check({tag, "_state"},   sup.state, S_RESET);
    endtask

    // Holds rst for two edges, checks reset values, releases just after an edge.
    task automatic do_reset(input logic locked);
        rst = 1'b1;
        sup.pll_locked  = locked;
        sup.clear_fault = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        check_reset_values("in_reset");
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_ready(input logic want, input int budget, input string name);
        int n = 0;
        while (sup.ready !== want && n < budget) begin
            tick();
            n++;
        end
        check(name, sup.ready, want);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int     cycles;
        logic   locked;
        state_t st;
        logic   prst;
        logic   srst;
        logic   rdy;
        logic   flt;
        int     loss;
    } vec_t;

    vec_t vecs[11];

    initial begin
        rst = 1'b1;
        sup.pll_locked  = 1'b0;
        sup.clear_fault = 1'b0;

        // Scenario 1 (lock from cycle 10) followed by a one-cycle drop in RUN.
        vecs[0]  = '{3, 1'b0, S_RESET,     1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{6, 1'b0, S_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{2, 1'b1, S_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[3]  = '{8, 1'b1, S_STABLE,    1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[4]  = '{5, 1'b1, S_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[5]  = '{1, 1'b0, S_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[6]  = '{1, 1'b1, S_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[7]  = '{4, 1'b1, S_RESET,     1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{1, 1'b1, S_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{8, 1'b1, S_STABLE,    1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[10] = '{3, 1'b1, S_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 1};

        do_reset(1'b0);
        foreach (vecs[i]) begin
            sup.pll_locked = vecs[i].locked;
            for (int k = 0; k < vecs[i].cycles; k++) begin
                tick();
                check($sformatf("v%0d_state", i),   sup.state,   vecs[i].st);
                check($sformatf("v%0d_pll_rst", i), sup.pll_rst, vecs[i].prst);
                check($sformatf("v%0d_sys_rst", i), sup.sys_rst, vecs[i].srst);
                check($sformatf("v%0d_ready", i),   sup.ready,   vecs[i].rdy);
                check($sformatf("v%0d_fault", i),   sup.fault,   vecs[i].flt);
                check($sformatf("v%0d_loss", i),    sup.lock_loss_count, vecs[i].loss);
                check($sformatf("v%0d_retry", i),   sup.retry_count, 0);
            end
        end

        // Scenario 2: never locks -> two timeouts -> FAULT; stray clear_fault in WAIT ignored.
        do_reset(1'b0);
        for (int c = 1; c <= 75; c++) begin
            sup.clear_fault = (c == 20);
            tick();
            check("s2_pll_rst", sup.pll_rst,
                  (c < 4) || (c >= 36 && c < 40) || (c >= 72));
            check("s2_fault", sup.fault, c >= 72);
            if (c == 36) check("s2_retry_1", sup.retry_count, 1);
        end
        check("s2_retry_2", sup.retry_count, 2);
        check("s2_state_fault", sup.state, S_FAULT);
        check("s2_sys_rst", sup.sys_rst, 1);

        sup.clear_fault = 1'b1;
        tick();
        sup.clear_fault = 1'b0;
        check("s2_clr_fault", sup.fault, 0);
        check("s2_clr_retry", sup.retry_count, 0);
        check("s2_clr_state", sup.state, S_RESET);
        for (int k = 0; k < 4; k++) begin
            check("s2_clr_pulse", sup.pll_rst, 1);
            tick();
        end
        check("s2_clr_pulse_end", sup.pll_rst, 0);
        check("s2_clr_wait", sup.state, S_WAIT_LOCK);
        repeat (32) tick();
        check("s2_retry_again", sup.retry_count, 1);
        check("s2_retry_state", sup.state, S_RESET);
        sup.pll_locked = 1'b1;
        wait_ready(1'b1, 40, "s2_relock_ready");
        check("s2_run_retry_cleared", sup.retry_count, 0);
        check("s2_run_sys_rst", sup.sys_rst, 0);

        // Scenario 4: one-cycle lock glitch in STABLE restarts qualification.
        do_reset(1'b1);
        run_to(7);
        check("s4_state_stable", sup.state, S_STABLE);
        sup.pll_locked = 1'b0;
        tick();
        sup.pll_locked = 1'b1;
        run_to(10);
        check("s4_back_to_wait", sup.state, S_WAIT_LOCK);
        check("s4_retry", sup.retry_count, 0);
        tick();
        check("s4_restable", sup.state, S_STABLE);
        while (cyc < 18) begin
            tick();
            check("s4_no_early_ready", sup.ready, 0);
        end
        tick();
        check("s4_ready_19", sup.ready, 1);
        check("s4_retry_run", sup.retry_count, 0);

        // Scenario 6a: async reset in the middle of STABLE.
        do_reset(1'b1);
        run_to(8);
        check("s6a_in_stable", sup.state, S_STABLE);
        #3 rst = 1'b1;
        #1 check_reset_values("s6a_async");

        // Scenario 5: 300 lock-loss events, counter saturates at 255.
        do_reset(1'b1);
        for (int i = 1; i <= 300; i++) begin
            wait_ready(1'b1, 60, "s5_ready");
            sup.pll_locked = 1'b0;
            tick();
            sup.pll_locked = 1'b1;
            wait_ready(1'b0, 10, "s5_drop");
            check($sformatf("s5_loss_%0d", i), sup.lock_loss_count, (i > 255) ? 255 : i);
        end
        wait_ready(1'b1, 60, "s5_final_ready");
        check("s5_run", sup.state, S_RUN);

        // Scenario 6b: async reset in the middle of RUN clears the saturated counter.
        #3 rst = 1'b1;
        #1 check_reset_values("s6b_async");
        do_reset(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
